dram_wb_arbiter: RTL and testbench
==================================

# dram_wb_arbiter

Round-robin arbiter that shares the single Wishbone-classic slave port of the DRAM wrapper among `NUM_MASTERS` requesters (e.g. CPU data port, DMA, video fetch). It sits between the requesters and the wrapper, holds requests until the wrapper reports `initialized`, and forwards exactly one transaction at a time. It returns the response to the granted master only.

## Interface
- `NUM_MASTERS`, 4: requester count, 2..8.
- `WORD_SIZE`, 256: data width in bits; must match the wrapper.
- `ADDR_WIDTH`, 32: Wishbone byte-address width.
- `TIMEOUT_CYCLES`, 4096: watchdog limit. Used only with `DRAM_ARB_TIMEOUT_EN`.

Ports:
- `sys_clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `initialized_i` in 1: DRAM calibration done, from the wrapper.
- `m_cyc_i`, `m_stb_i`, `m_we_i` in NUM_MASTERS each: per-master Wishbone strobes.
- `m_addr_i` in NUM_MASTERS*ADDR_WIDTH: packed addresses; master i occupies slice i.
- `m_data_i` in NUM_MASTERS*WORD_SIZE: packed write data.
- `m_data_o` out WORD_SIZE: shared read data, valid only with that master's ack.
- `m_ack_o` out NUM_MASTERS: one-hot, single-cycle acknowledge.
- `m_err_o` out NUM_MASTERS: one-hot, single-cycle timeout error. Constant 0 without the macro.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1 each: strobes to the wrapper.
- `s_addr_o` out ADDR_WIDTH: address to the wrapper.
- `s_data_o` out WORD_SIZE: write data to the wrapper.
- `s_data_i` in WORD_SIZE: read data from the wrapper.
- `s_ack_i` in 1: acknowledge from the wrapper.
- `grant_o` out $clog2(NUM_MASTERS): index of the current or last-granted master (debug).

## Operation
- **Reset values:** all outputs 0; state IDLE; round-robin pointer `last_grant` = NUM_MASTERS-1, so master 0 has first priority.
- **Request:** master i requests when `m_cyc_i[i] & m_stb_i[i]`.
- **States:**
  - IDLE → BUSY when `initialized_i` = 1 and any request is present.
  - BUSY → RELEASE on `s_ack_i`, or on watchdog expiry.
  - RELEASE → IDLE unconditionally.
- **Winner selection:** the first requester found scanning upward from `last_grant+1`, wrapping modulo NUM_MASTERS. `last_grant` is updated to the winner on the IDLE→BUSY transition.
- **Registered on grant:** the winner's `we`, `addr` and `data` are copied into the `s_*` registers, and `s_cyc_o`/`s_stb_o` are set to 1. All of these are held constant through BUSY.
- **Acknowledge:** on `s_ack_i` in BUSY:
  - `m_data_o` ← `s_data_i`.
  - `m_ack_o[grant]` ← 1.
  - `s_cyc_o`/`s_stb_o` ← 0.
- **Master abort:** if the granted master drops `cyc` during BUSY, the slave cycle still completes (the wrapper cannot abort) and the ack is suppressed.
- **Stray acks:** `s_ack_i` in IDLE or RELEASE is ignored.
- **`initialized_i` falls during BUSY:** the transaction continues; no new grants are issued until `initialized_i` returns.

## Timing
- Request sampled at edge t → `s_cyc_o`/`s_stb_o` high from t+1. Minimum latency is 1 cycle.
- `s_ack_i` sampled at edge k → `m_ack_o` and `m_data_o` valid during cycle k+1, and `s_cyc_o` is low in the same cycle.
- RELEASE occupies cycle k+1, giving the master time to drop `cyc`. IDLE samples at k+2, so the next `s_cyc_o` rises at k+3 at the earliest.
- `s_cyc_o` is low for at least 2 cycles between transactions.
- Masters must hold `cyc`/`stb`/`addr`/`data` until ack. Changes after the grant edge are not forwarded.
- Fairness: a continuously requesting master waits at most NUM_MASTERS-1 transactions.

## Configuration
- Macro `DRAM_ARB_TIMEOUT_EN`.
- **Defined:** a counter clears on grant and increments every BUSY cycle. When it reaches TIMEOUT_CYCLES-1 without `s_ack_i`:
  - `m_err_o[grant]` pulses for 1 cycle and `m_ack_o` stays 0.
  - `s_cyc_o`/`s_stb_o` drop, and the state goes to RELEASE.
  - If ack and expiry occur in the same cycle, the ack wins.
- **Undefined:** no counter; `m_err_o` is tied to 0; BUSY waits indefinitely.

## Structure
- Package `dram_arb_pkg`:
  - `arb_state_t` enum {IDLE, BUSY, RELEASE}.
  - Default width constants.
- Sub-module `rr_arbiter`: purely combinational. Inputs are the request vector and `last_grant`; outputs are the one-hot grant and its index. Instantiated once.

## Test plan
- **Hold until init:** `initialized_i`=0, master 1 requests → no `s_cyc_o`. After init rises, `s_cyc_o` rises 1 cycle later with master 1's address 0x280.
- **Single write then read:** master 0 writes `{32{8'hA5}}` to 0x0, then reads 0x0 with a wrapper model → `m_ack_o`=4'b0001 and `m_data_o`=`{32{8'hA5}}`.
- **Rotation:** all 4 masters request continuously → grant order 0,1,2,3,0. Each master's `s_addr_o` matches its own slice.
- **Abort and stray ack:** master 2 drops `cyc` mid-BUSY → no `m_ack_o`. An extra `s_ack_i` injected in IDLE → no output change.
- **Reset mid-operation:** `rst_n` low during BUSY → all outputs 0 immediately. After release, master 0 has first priority.
- **Timeout (macro on, TIMEOUT_CYCLES=16):** wrapper never acks → `m_err_o[grant]` pulses at the 16th BUSY cycle. The next master is granted 2 cycles later.

Source files
------------

// File: rtl/dram_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : dram_arb_pkg                                               |
// | Purpose  : Shared types and default widths for the DRAM Wishbone      |
// |            arbiter.                                                   |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package dram_arb_pkg;

  localparam int unsigned DEF_NUM_MASTERS    = 4;
  localparam int unsigned DEF_WORD_SIZE      = 256;
  localparam int unsigned DEF_ADDR_WIDTH     = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_arbiter                                                 |
// | Purpose  : Combinational round-robin pick. Scans upward from the      |
// |            master after last_grant_i, wrapping, and returns the first |
// |            requester as one-hot plus index.                           |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]       last_grant_i,
  output logic                   valid_o,
  output logic [NUM_MASTERS-1:0] gnt_oh_o,
  output logic [IDX_W-1:0]       gnt_idx_o
);

  // One extra bit so last_grant + offset cannot overflow before the wrap
  logic [IDX_W:0] cand;
  logic           found;

  // Priority scan starting just above the previous winner
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int off = 1; off <= int'(NUM_MASTERS); off++) begin
      cand = {1'b0, last_grant_i} + (IDX_W+1)'(off);
      if (cand >= (IDX_W+1)'(NUM_MASTERS)) begin
        cand = cand - (IDX_W+1)'(NUM_MASTERS);
      end
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found                       = 1'b1;
        gnt_idx_o                   = cand[IDX_W-1:0];
        gnt_oh_o[cand[IDX_W-1:0]]   = 1'b1;
      end
    end
  end

  assign valid_o = found;

endmodule
`default_nettype wire

// File: rtl/dram_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dram_wb_arbiter                                            |
// | Purpose  : Round-robin arbiter sharing the DRAM wrapper's Wishbone    |
// |            classic slave port between NUM_MASTERS requesters. One     |
// |            transaction at a time, held off until calibration is done. |
// | Options  : DRAM_ARB_TIMEOUT_EN - BUSY watchdog that returns m_err_o   |
// |            after TIMEOUT_CYCLES cycles without s_ack_i.               |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module dram_wb_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = DEF_NUM_MASTERS,
  parameter int unsigned WORD_SIZE      = DEF_WORD_SIZE,
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                              sys_clk,
  input  logic                              rst_n,
  input  logic                              initialized_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS*WORD_SIZE-1:0]  m_data_i,
  output logic [WORD_SIZE-1:0]              m_data_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_addr_o,
  output logic [WORD_SIZE-1:0]              s_data_o,
  input  logic [WORD_SIZE-1:0]              s_data_i,
  input  logic                              s_ack_i,
  output logic [$clog2(NUM_MASTERS)-1:0]    grant_o
);

  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("dram_wb_arbiter: illegal parameter set");
  end

  arb_state_t state_q, state_d;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] win_oh;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_valid;
  logic                   start;
  logic                   tmo_expire;

  logic                   sel_we;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [WORD_SIZE-1:0]   sel_data;

  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [NUM_MASTERS-1:0] gnt_oh_q, gnt_oh_d;
  logic                   aborted_q, aborted_d;
  logic                   cyc_q, cyc_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
  logic [WORD_SIZE-1:0]   rdata_q, rdata_d;
  logic [NUM_MASTERS-1:0] ack_q, ack_d;
  logic [NUM_MASTERS-1:0] err_q, err_d;

  assign req   = m_cyc_i & m_stb_i;
  assign start = (state_q == IDLE) && initialized_i && win_valid;

  rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_rr_arbiter (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .valid_o      (win_valid),
    .gnt_oh_o     (win_oh),
    .gnt_idx_o    (win_idx)
  );

  // Steer the winning master's request fields using its one-hot grant
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (win_oh[i]) begin
        sel_we   = m_we_i[i];
        sel_addr = m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = m_data_i[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

`ifdef DRAM_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Watchdog: held at zero outside BUSY (so it is clear at grant), counts BUSY cycles
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == BUSY) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end else begin
      tmo_cnt_d = '0;
    end
  end

  // Watchdog counter register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // A same-cycle ack takes precedence over expiry
  assign tmo_expire = (state_q == BUSY) && !s_ack_i &&
                      (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_expire = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (s_ack_i || tmo_expire) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: latch the grant, close the slave cycle, pulse ack/err
  always_comb begin
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    gnt_oh_d     = gnt_oh_q;
    aborted_d    = aborted_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    ack_d        = '0;
    err_d        = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          last_grant_d = win_idx;
          grant_d      = win_idx;
          gnt_oh_d     = win_oh;
          aborted_d    = 1'b0;
          cyc_d        = 1'b1;
          we_d         = sel_we;
          addr_d       = sel_addr;
          wdata_d      = sel_data;
        end
      end
      BUSY: begin
        // Once the granted master lets go of cyc its ack is withheld for good
        if ((gnt_oh_q & ~m_cyc_i) != '0) begin
          aborted_d = 1'b1;
        end
        if (s_ack_i) begin
          cyc_d   = 1'b0;
          rdata_d = s_data_i;
          if (!aborted_q) begin
            ack_d = gnt_oh_q & m_cyc_i;
          end
        end else if (tmo_expire) begin
          cyc_d = 1'b0;
          err_d = gnt_oh_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath and handshake registers
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= IDX_W'(NUM_MASTERS - 1);
      grant_q      <= '0;
      gnt_oh_q     <= '0;
      aborted_q    <= 1'b0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      ack_q        <= '0;
      err_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      gnt_oh_q     <= gnt_oh_d;
      aborted_q    <= aborted_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
    end
  end

  assign s_cyc_o  = cyc_q;
  assign s_stb_o  = cyc_q;
  assign s_we_o   = we_q;
  assign s_addr_o = addr_q;
  assign s_data_o = wdata_q;
  assign m_data_o = rdata_q;
  assign m_ack_o  = ack_q;
  assign m_err_o  = err_q;
  assign grant_o  = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_dram_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_dram_wb_arbiter                                         |
// | Purpose  : Self-checking bench for dram_wb_arbiter with a wrapper     |
// |            model and grant/response scoreboards.                      |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_dram_wb_arbiter;

  localparam int NM = 4;
  localparam int WS = 256;
  localparam int AW = 32;

  logic              sys_clk = 1'b0;
  logic              rst_n;
  logic              initialized_i;
  logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
  logic [NM*AW-1:0]  m_addr_i;
  logic [NM*WS-1:0]  m_data_i;
  logic [WS-1:0]     m_data_o;
  logic [NM-1:0]     m_ack_o, m_err_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]     s_addr_o;
  logic [WS-1:0]     s_data_o;
  logic [WS-1:0]     s_data_i;
  logic              s_ack_i;
  logic [1:0]        grant_o;

  dram_wb_arbiter #(
    .NUM_MASTERS    (NM),
    .WORD_SIZE      (WS),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .initialized_i (initialized_i),
    .m_cyc_i       (m_cyc_i),
    .m_stb_i       (m_stb_i),
    .m_we_i        (m_we_i),
    .m_addr_i      (m_addr_i),
    .m_data_i      (m_data_i),
    .m_data_o      (m_data_o),
    .m_ack_o       (m_ack_o),
    .m_err_o       (m_err_o),
    .s_cyc_o       (s_cyc_o),
    .s_stb_o       (s_stb_o),
    .s_we_o        (s_we_o),
    .s_addr_o      (s_addr_o),
    .s_data_o      (s_data_o),
    .s_data_i      (s_data_i),
    .s_ack_i       (s_ack_i),
    .grant_o       (grant_o)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc_cnt = 0;
  always @(posedge sys_clk) cyc_cnt <= cyc_cnt + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { logic [1:0] idx; logic [31:0] addr; logic we; logic [255:0] data; } gexp_t;
  typedef struct { logic [3:0] ack; logic [3:0] err; logic [255:0] data; bit chk_data; } aexp_t;
  typedef struct { int m; bit we; logic [31:0] addr; logic [255:0] wdata;
                   logic [3:0] exp_ack; logic [255:0] exp_rdata; } vec_t;

  gexp_t exp_g[$];
  aexp_t exp_a[$];

  function automatic logic [255:0] rd_pat(input logic [31:0] a);
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- wrapper model ----------------
  bit  wrap_en   = 1'b1;
  int  wrap_lat  = 1;
  bit  stray_ack = 1'b0;
  int  wcnt      = 0;
  logic [255:0] mem [logic [31:0]];

  initial begin
    s_ack_i  = 1'b0;
    s_data_i = '0;
    forever begin
      @(negedge sys_clk);
      s_ack_i = stray_ack;
      if (wrap_en && rst_n && s_cyc_o && s_stb_o) begin
        if (wcnt >= wrap_lat) begin
          s_ack_i = 1'b1;
          wcnt    = 0;
          if (s_we_o) mem[s_addr_o] = s_data_o;
          else        s_data_i = mem.exists(s_addr_o) ? mem[s_addr_o] : rd_pat(s_addr_o);
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int ack_count = 0;
  bit prev_cyc  = 1'b0;

  initial begin : mon
    gexp_t g;
    aexp_t a;
    forever begin
      @(negedge sys_clk);
      if (s_cyc_o && !prev_cyc) begin
        if (exp_g.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL grant_unexpected actual=%0d required=none", grant_o);
        end else begin
          g = exp_g.pop_front();
          check("grant_idx",  grant_o,  g.idx);
          check("grant_addr", s_addr_o, g.addr);
          check("grant_we",   s_we_o,   g.we);
          check("grant_stb",  s_stb_o,  1'b1);
          if (g.we) check("grant_wdata", s_data_o, g.data);
        end
      end
      if ((m_ack_o != '0) || (m_err_o != '0)) begin
        ack_count++;
        if (exp_a.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL resp_unexpected actual=ack%b_err%b required=none", m_ack_o, m_err_o);
        end else begin
          a = exp_a.pop_front();
          check("resp_ack", m_ack_o, a.ack);
          check("resp_err", m_err_o, a.err);
          check("resp_cyc_low", s_cyc_o, 1'b0);
          if (a.chk_data) check("resp_rdata", m_data_o, a.data);
        end
      end
      prev_cyc = s_cyc_o;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int m, input bit on, input bit we,
                         input logic [31:0] addr, input logic [255:0] data);
    m_cyc_i[m]           = on;
    m_stb_i[m]           = on;
    m_we_i[m]            = we;
    m_addr_i[m*AW +: AW] = addr;
    m_data_i[m*WS +: WS] = data;
  endtask

  task automatic wait_resp(input int m, input string name);
    for (int n = 0; n < 100; n++) begin
      @(negedge sys_clk);
      if (m_ack_o[m] || m_err_o[m]) return;
    end
    n_checks++; n_fail++;
    $display("FAIL %s actual=no_response required=response", name);
  endtask

  task automatic wait_cyc(input bit lvl, input string name);
    for (int n = 0; n < 100; n++) begin
      @(negedge sys_clk);
      if (s_cyc_o == lvl) return;
    end
    n_checks++; n_fail++;
    $display("FAIL %s actual=s_cyc_stuck required=%0d", name, lvl);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[7];

  initial begin
    int             acks;
    int             t_rise, t_err;
    logic [255:0]   snap_data;
    logic [1:0]     snap_grant;
    int             snap_cnt;

    vecs[0] = '{0, 1'b1, 32'h0,  {32{8'hA5}},        4'b0001, '0};
    vecs[1] = '{0, 1'b0, 32'h0,  '0,                 4'b0001, {32{8'hA5}}};
    vecs[2] = '{1, 1'b1, 32'h20, {8{32'h1234_5678}}, 4'b0010, '0};
    vecs[3] = '{3, 1'b0, 32'h20, '0,                 4'b1000, {8{32'h1234_5678}}};
    vecs[4] = '{2, 1'b1, 32'h40, {16{16'hBEEF}},     4'b0100, '0};
    vecs[5] = '{2, 1'b0, 32'h40, '0,                 4'b0100, {16{16'hBEEF}}};
    vecs[6] = '{3, 1'b0, 32'h60, '0,                 4'b1000, rd_pat(32'h60)};

    rst_n = 1'b0; initialized_i = 1'b0;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_addr_i = '0; m_data_i = '0;
    repeat (3) @(negedge sys_clk);
    check("rst_s_cyc",  s_cyc_o,  1'b0);
    check("rst_s_stb",  s_stb_o,  1'b0);
    check("rst_s_we",   s_we_o,   1'b0);
    check("rst_s_addr", s_addr_o, '0);
    check("rst_s_data", s_data_o, '0);
    check("rst_m_ack",  m_ack_o,  '0);
    check("rst_m_err",  m_err_o,  '0);
    check("rst_m_data", m_data_o, '0);
    check("rst_grant",  grant_o,  '0);
    rst_n = 1'b1;

    // Hold until initialized
    @(negedge sys_clk);
    set_req(1, 1'b1, 1'b0, 32'h280, '0);
    repeat (5) @(negedge sys_clk);
    check("init_hold_cyc", s_cyc_o, 1'b0);
    exp_g.push_back('{2'd1, 32'h280, 1'b0, '0});
    exp_a.push_back('{4'b0010, 4'b0000, rd_pat(32'h280), 1'b1});
    initialized_i = 1'b1;
    @(negedge sys_clk);
    check("init_cyc_rise", s_cyc_o,  1'b1);
    check("init_addr",     s_addr_o, 32'h280);
    wait_resp(1, "init_resp");
    set_req(1, 1'b0, 1'b0, 32'h280, '0);

    // Table-driven single transactions
    for (int i = 0; i < 7; i++) begin
      set_req(vecs[i].m, 1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      exp_g.push_back('{vecs[i].m[1:0], vecs[i].addr, vecs[i].we, vecs[i].wdata});
      exp_a.push_back('{vecs[i].exp_ack, 4'b0000, vecs[i].exp_rdata, !vecs[i].we});
      wait_resp(vecs[i].m, "vec_resp");
      set_req(vecs[i].m, 1'b0, 1'b0, '0, '0);
    end

    // Rotation: all four request continuously, order 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      exp_g.push_back('{2'(i % 4), 32'h1000 + 32'((i % 4) * 256), 1'b0, '0});
      exp_a.push_back('{4'(1 << (i % 4)), 4'b0000, rd_pat(32'h1000 + 32'((i % 4) * 256)), 1'b1});
    end
    for (int m = 0; m < 4; m++) set_req(m, 1'b1, 1'b0, 32'h1000 + 32'(m * 256), '0);
    acks = 0;
    for (int n = 0; n < 200 && acks < 5; n++) begin
      @(negedge sys_clk);
      if (m_ack_o != '0) acks++;
      if (acks == 5) for (int m = 0; m < 4; m++) set_req(m, 1'b0, 1'b0, '0, '0);
    end
    check("rot_ack_count", acks, 5);

    // Master abort: master 2 drops cyc mid-BUSY, slave completes, no ack
    wrap_lat = 4;
    snap_cnt = ack_count;
    exp_g.push_back('{2'd2, 32'h300, 1'b1, {8{32'hABCD_0123}}});
    set_req(2, 1'b1, 1'b1, 32'h300, {8{32'hABCD_0123}});
    wait_cyc(1'b1, "abort_grant");
    set_req(2, 1'b0, 1'b1, 32'h300, {8{32'hABCD_0123}});
    wait_cyc(1'b0, "abort_complete");
    check("abort_no_ack_now", m_ack_o, '0);
    repeat (3) @(negedge sys_clk);
    check("abort_no_ack_count", ack_count, snap_cnt);
    wrap_lat = 1;

    // Stray ack while IDLE
    snap_data  = m_data_o;
    snap_grant = grant_o;
    @(posedge sys_clk); stray_ack = 1'b1;
    @(posedge sys_clk); stray_ack = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("stray_ack_out",  m_ack_o,  '0);
    check("stray_cyc",      s_cyc_o,  1'b0);
    check("stray_data",     m_data_o, snap_data);
    check("stray_grant",    grant_o,  snap_grant);

    // Reset during BUSY
    wrap_en = 1'b0;
    exp_g.push_back('{2'd0, 32'h400, 1'b0, '0});
    set_req(0, 1'b1, 1'b0, 32'h400, '0);
    wait_cyc(1'b1, "rstmid_grant");
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    #1;
    check("rstmid_cyc",  s_cyc_o,  1'b0);
    check("rstmid_stb",  s_stb_o,  1'b0);
    check("rstmid_addr", s_addr_o, '0);
    check("rstmid_data", m_data_o, '0);
    check("rstmid_grant", grant_o, '0);
    repeat (2) @(negedge sys_clk);
    rst_n   = 1'b1;
    wrap_en = 1'b1;
    exp_g.push_back('{2'd0, 32'h500, 1'b0, '0});
    exp_a.push_back('{4'b0001, 4'b0000, rd_pat(32'h500), 1'b1});
    exp_g.push_back('{2'd2, 32'h520, 1'b0, '0});
    exp_a.push_back('{4'b0100, 4'b0000, rd_pat(32'h520), 1'b1});
    set_req(2, 1'b1, 1'b0, 32'h520, '0);
    set_req(0, 1'b1, 1'b0, 32'h500, '0);
    wait_resp(0, "rstmid_m0");
    set_req(0, 1'b0, 1'b0, '0, '0);
    wait_resp(2, "rstmid_m2");
    set_req(2, 1'b0, 1'b0, '0, '0);

`ifdef DRAM_ARB_TIMEOUT_EN
    // Watchdog expiry, then the next master follows two cycles later
    wrap_en = 1'b0;
    exp_g.push_back('{2'd1, 32'h600, 1'b0, '0});
    exp_a.push_back('{4'b0000, 4'b0010, '0, 1'b0});
    exp_g.push_back('{2'd2, 32'h620, 1'b0, '0});
    exp_a.push_back('{4'b0100, 4'b0000, rd_pat(32'h620), 1'b1});
    set_req(1, 1'b1, 1'b0, 32'h600, '0);
    set_req(2, 1'b1, 1'b0, 32'h620, '0);
    wait_cyc(1'b1, "tmo_grant");
    t_rise = cyc_cnt;
    wait_resp(1, "tmo_err");
    t_err = cyc_cnt;
    wrap_en = 1'b1;
    set_req(1, 1'b0, 1'b0, '0, '0);
    check("tmo_busy_cycles", 32'(t_err - t_rise), 32'd16);
    wait_cyc(1'b1, "tmo_regrant");
    check("tmo_regrant_gap", 32'(cyc_cnt - t_err), 32'd2);
    wait_resp(2, "tmo_m2");
    set_req(2, 1'b0, 1'b0, '0, '0);
`else
    t_rise = 0;
    t_err  = 0;
`endif

    repeat (4) @(negedge sys_clk);
    check("grant_queue_empty", 32'(exp_g.size()), 32'd0);
    check("resp_queue_empty",  32'(exp_a.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
